// File: rtl/nx_ctrl_host.sv
// Host-side endpoint of the accelerator control stream: forwards one request
// at a time to the device and buffers its response beats for the host.
module nx_ctrl_host #(
    parameter int REQ_W   = 32,
    parameter int RSP_W   = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [REQ_W-1:0]           i_cmd_data,
    input  logic                       i_cmd_expect,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    output logic [REQ_W-1:0]           o_ctrl_in_data,
    output logic                       o_ctrl_in_valid,
    input  logic                       i_ctrl_in_ready,
    input  logic [RSP_W-1:0]           i_ctrl_out_data,
    input  logic                       i_ctrl_out_last,
    input  logic                       i_ctrl_out_valid,
    output logic                       o_ctrl_out_ready,
    output logic [RSP_W-1:0]           o_rsp_data,
    output logic                       o_rsp_last,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [$clog2(DEPTH+1)-1:0] o_rsp_count,
    output logic                       o_busy,
    output logic                       o_timeout,
    output logic                       o_unsolicited
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int TO_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT} state_t;

    state_t             state, state_nxt;
    logic               rst_meta, rst_sync;
    logic [REQ_W-1:0]   req_data;
    logic               req_expect;
    logic [TO_W-1:0]    to_cnt;
    logic [RSP_W:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, cmd_hs, beat_hs, push, pop, to_fire;

    // Reset asserts asynchronously but is released on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    assign full    = (count == CNT_W'(DEPTH));
    assign cmd_hs  = i_cmd_valid && o_cmd_ready;
    assign beat_hs = i_ctrl_out_valid && o_ctrl_out_ready;
    assign push    = (state == ST_WAIT) && beat_hs;
    assign pop     = o_rsp_valid && i_rsp_ready;
    assign to_fire = (state == ST_WAIT) && !beat_hs && (to_cnt == TO_W'(TIMEOUT-1));

    always_ff @(posedge i_clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        o_cmd_ready      = 1'b0;
        o_ctrl_in_valid  = 1'b0;
        o_ctrl_out_ready = 1'b1;
        o_busy           = 1'b1;
        case (state)
            ST_IDLE: begin
                o_cmd_ready = 1'b1;
                o_busy      = 1'b0;
                if (i_cmd_valid) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                o_ctrl_in_valid = 1'b1;
                if (i_ctrl_in_ready) state_nxt = req_expect ? ST_WAIT : ST_IDLE;
            end
            ST_WAIT: begin
                o_ctrl_out_ready = !full;
                if ((i_ctrl_out_valid && !full && i_ctrl_out_last) || to_fire)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge rst_sync) begin
        if (!rst_sync) begin
            req_data      <= '0;
            req_expect    <= 1'b0;
            to_cnt        <= '0;
            o_timeout     <= 1'b0;
            o_unsolicited <= 1'b0;
        end else begin
            if (cmd_hs) begin
                req_data      <= i_cmd_data;
                req_expect    <= i_cmd_expect;
                o_timeout     <= 1'b0;
                o_unsolicited <= 1'b0;
            end
            // A beat outside WAIT is dropped; flagging it wins over the clear.
            if (beat_hs && state != ST_WAIT) o_unsolicited <= 1'b1;
            if (to_fire) o_timeout <= 1'b1;
            if (state != ST_WAIT || beat_hs) to_cnt <= '0;
            else                             to_cnt <= to_cnt + TO_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= {i_ctrl_out_last, i_ctrl_out_data};
    end

    always_ff @(posedge i_clk or negedge rst_sync) begin
        if (!rst_sync) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CNT_W'(1);
            else if (pop && !push) count <= count - CNT_W'(1);
        end
    end

    assign o_ctrl_in_data = req_data;
    assign o_rsp_data     = mem[rd_ptr][RSP_W-1:0];
    assign o_rsp_last     = mem[rd_ptr][RSP_W];
    assign o_rsp_valid    = (count != '0);
    assign o_rsp_count    = count;

endmodule
